// File: rtl/sample_player_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sample_player_pkg
//  Purpose  : Shared widths and state encoding for the sample player.
//  Revision : 1.0  initial release
// ============================================================================
package sample_player_pkg;

  localparam int DIV_WIDTH  = 24;
  localparam int SMPL_WIDTH = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } player_state_t;

endpackage
`default_nettype wire

// File: rtl/sample_player_if.sv
`default_nettype none
// ============================================================================
//  Module   : sample_player_if
//  Purpose  : Host-side control/data bundle of the sample player.
//  Revision : 1.0  initial release
// ============================================================================
interface sample_player_if
  import sample_player_pkg::*;
#(
  parameter int WIDTH = SMPL_WIDTH
);

  logic [DIV_WIDTH-1:0] fdiv_i;
  logic                 set_div_i;
  logic                 en_i;
  logic                 clr_i;
  logic [WIDTH-1:0]     smpls_i;
  logic                 stb_i;
  logic [WIDTH-1:0]     data_o;
  logic                 tick_o;
  logic                 full_o;
  logic                 empty_o;
  logic                 ovf_o;
  logic                 udf_o;

  // Host / command path drives the controls and observes the outputs
  modport master (
    output fdiv_i, set_div_i, en_i, clr_i, smpls_i, stb_i,
    input  data_o, tick_o, full_o, empty_o, ovf_o, udf_o
  );

  // Player side
  modport slave (
    input  fdiv_i, set_div_i, en_i, clr_i, smpls_i, stb_i,
    output data_o, tick_o, full_o, empty_o, ovf_o, udf_o
  );

endinterface
`default_nettype wire

// File: rtl/sample_player_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : player_fifo
//  Purpose  : Synchronous FIFO with registered full/empty flags and a
//             flush input. Pointers carry one extra MSB so full and empty
//             are distinguishable when the index bits match.
//  Revision : 1.0  initial release
// ============================================================================
module player_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_in,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             r_full;
  logic             r_empty;
  logic [AW:0]      w_wptr_nxt;
  logic [AW:0]      w_rptr_nxt;

  assign w_wptr_nxt = r_wptr + (AW+1)'(push_i);
  assign w_rptr_nxt = r_rptr + (AW+1)'(pop_i);

  // Storage array; no reset needed, contents are qualified by the pointers
  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i) begin
      r_mem[r_wptr[AW-1:0]] <= wdata_i;
    end
  end

  // Pointer and flag update; flush has priority over push/pop
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else if (clr_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_full  <= (w_wptr_nxt[AW] != w_rptr_nxt[AW]) &&
                 (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]);
      r_empty <= (w_wptr_nxt == w_rptr_nxt);
    end
  end

  assign rdata_o = r_mem[r_rptr[AW-1:0]];
  assign full_o  = r_full;
  assign empty_o = r_empty;

endmodule
`default_nettype wire

// File: rtl/sample_player.sv
`default_nettype none
// ============================================================================
//  Module   : sample_player
//  Purpose  : Buffers strobed sample words in a FIFO and replays them on
//             data_o, one word every fdiv+1 clocks while enabled.
//  Revision : 1.0  initial release
// ============================================================================
module sample_player
  import sample_player_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = SMPL_WIDTH
) (
  input  logic            clk_i,
  input  logic            rst_in,
  sample_player_if.slave  bus
);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_RUN  = RUN;

  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [0:0]           r_state;
  logic [WIDTH-1:0]     r_data;
  logic                 r_tick;
  logic                 r_ovf;
  logic                 r_udf;

  logic                 w_tick_ev;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_full;
  logic                 w_empty;
  logic [WIDTH-1:0]     w_head;
  logic [DIV_WIDTH-1:0] w_reload;

  // A tick is due when the running period counter reaches zero; a cycle
  // in which en_i drops never ticks.
  assign w_tick_ev = (r_state == ST_RUN) && bus.en_i && (r_cnt == '0);
  // Flush blocks both pop and push. A full FIFO still accepts a word when
  // the same edge frees a slot.
  assign w_pop     = w_tick_ev && !w_empty && !bus.clr_i;
  assign w_push    = bus.stb_i && !bus.clr_i && (!w_full || w_pop);
  // A newly written divider is used immediately for any reload this cycle
  assign w_reload  = bus.set_div_i ? bus.fdiv_i : r_div;

  player_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_in  (rst_in),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .clr_i   (bus.clr_i),
    .wdata_i (bus.smpls_i),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // Divider register
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_div <= '0;
    end else if (bus.set_div_i) begin
      r_div <= bus.fdiv_i;
    end
  end

  // Run/pause state machine and period counter
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= w_reload;
          if (bus.en_i) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!bus.en_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= w_reload;
          end else if (bus.set_div_i || (r_cnt == '0)) begin
            r_cnt <= w_reload;
          end else begin
            r_cnt <= r_cnt - DIV_WIDTH'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= r_div;
        end
      endcase
    end
  end

  // Output register: data_o and tick_o change together on a successful pop
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_data <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_pop;
      if (w_pop) begin
        r_data <= w_head;
      end
    end
  end

  // Sticky overflow / underflow flags, cleared by flush
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (bus.clr_i) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (bus.stb_i && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end
      if (w_tick_ev && w_empty) begin
        r_udf <= 1'b1;
      end
    end
  end

  assign bus.data_o  = r_data;
  assign bus.tick_o  = r_tick;
  assign bus.full_o  = w_full;
  assign bus.empty_o = w_empty;
  assign bus.ovf_o   = r_ovf;
  assign bus.udf_o   = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_sample_player.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sample_player
//  Purpose  : Self-checking bench for sample_player: queue-based reference
//             model compared every cycle, plus directed literal checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sample_player;
  import sample_player_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sample_player_if #(.WIDTH(32)) bus();

  sample_player #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) dut (
    .clk_i  (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: FIFO contents as a queue, replay timing as the
  // absolute edge number of the next due tick.
  logic [31:0] q[$];
  logic [31:0] m_data;
  bit          m_tick, m_ovf, m_udf, m_running;
  longint      m_div, m_next, cyc;

  function automatic void model_reset();
    q.delete();
    m_data    = '0;
    m_tick    = 1'b0;
    m_ovf     = 1'b0;
    m_udf     = 1'b0;
    m_running = 1'b0;
    m_div     = 0;
    m_next    = 0;
  endfunction

  // Advance the model by one rising edge using the inputs held across it
  function automatic void model_edge();
    bit     tick_ev, full_pre, empty_pre, pop, push;
    longint fd;
    cyc++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    fd        = longint'(bus.fdiv_i);
    tick_ev   = m_running && bus.en_i && (cyc == m_next);
    full_pre  = (q.size() == DEPTH);
    empty_pre = (q.size() == 0);
    pop       = tick_ev && !empty_pre && !bus.clr_i;
    push      = bus.stb_i && !bus.clr_i && (!full_pre || pop);
    if (m_running) begin
      if (!bus.en_i)          m_running = 1'b0;
      else if (bus.set_div_i) m_next = cyc + fd + 1;
      else if (tick_ev)       m_next = cyc + m_div + 1;
    end else if (bus.en_i) begin
      m_running = 1'b1;
      m_next    = cyc + 1 + (bus.set_div_i ? fd : m_div);
    end
    if (bus.set_div_i) m_div = fd;
    if (bus.clr_i) begin
      q.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_tick = 1'b0;
    end else begin
      m_tick = pop;
      if (pop) m_data = q.pop_front();
      if (tick_ev && empty_pre) m_udf = 1'b1;
      if (push) q.push_back(bus.smpls_i);
      if (bus.stb_i && full_pre && !pop) m_ovf = 1'b1;
    end
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %h expected %h (edge %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void lit(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    chk(nm, act, exp);
  endfunction

  // Compare every DUT output against the model
  function automatic void compare();
    vectors++;
    chk("data_o",  bus.data_o,          m_data);
    chk("tick_o",  32'(bus.tick_o),     32'(m_tick));
    chk("full_o",  32'(bus.full_o),     32'(q.size() == DEPTH));
    chk("empty_o", 32'(bus.empty_o),    32'(q.size() == 0));
    chk("ovf_o",   32'(bus.ovf_o),      32'(m_ovf));
    chk("udf_o",   32'(bus.udf_o),      32'(m_udf));
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
    bus.stb_i     = 1'b0;
    bus.set_div_i = 1'b0;
    bus.clr_i     = 1'b0;
  endtask

  task automatic wait_tick(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (bus.tick_o) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    bus.stb_i   = 1'b1;
    bus.smpls_i = w;
    step();
  endtask

  task automatic set_div(input int d);
    bus.fdiv_i    = 24'(d);
    bus.set_div_i = 1'b1;
    step();
  endtask

  task automatic flush();
    bus.clr_i = 1'b1;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          n;
    logic [31:0] w[8];

    cyc           = 0;
    rst_n         = 1'b0;
    bus.fdiv_i    = '0;
    bus.set_div_i = 1'b0;
    bus.en_i      = 1'b0;
    bus.clr_i     = 1'b0;
    bus.smpls_i   = '0;
    bus.stb_i     = 1'b0;
    model_reset();
    step();
    step();
    lit("rst_data",  bus.data_o, 32'h0);
    lit("rst_empty", 32'(bus.empty_o), 32'd1);
    lit("rst_full",  32'(bus.full_o),  32'd0);
    rst_n = 1'b1;
    step();

    // 1: fdiv=3, four words, one tick every 4 clocks, then underflow
    set_div(3);
    for (int i = 0; i < 4; i++) push_word(32'hA1 + 32'(i));
    bus.en_i = 1'b1;
    step();
    wait_tick(10, n);
    lit("t1_first_latency", 32'(n), 32'd4);
    lit("t1_word0", bus.data_o, 32'hA1);
    for (int k = 1; k < 4; k++) begin
      wait_tick(10, n);
      lit("t1_period", 32'(n), 32'd4);
      lit("t1_word", bus.data_o, 32'hA1 + 32'(k));
    end
    repeat (4) step();
    lit("t1_udf", 32'(bus.udf_o), 32'd1);
    lit("t1_hold", bus.data_o, 32'hA4);

    // 2: fdiv=0, eight back-to-back words
    bus.en_i = 1'b0;
    step();
    flush();
    set_div(0);
    for (int i = 0; i < 8; i++) begin
      w[i] = $urandom;
      push_word(w[i]);
    end
    bus.en_i = 1'b1;
    step();
    wait_tick(5, n);
    lit("t2_latency", 32'(n), 32'd1);
    lit("t2_word0", bus.data_o, w[0]);
    for (int i = 1; i < 8; i++) begin
      step();
      lit("t2_tick", 32'(bus.tick_o), 32'd1);
      lit("t2_word", bus.data_o, w[i]);
    end
    lit("t2_empty", 32'(bus.empty_o), 32'd1);
    bus.en_i = 1'b0;
    step();

    // 3: overfill while paused
    flush();
    for (int i = 0; i < 17; i++) begin
      push_word(32'h300 + 32'(i));
      if (i == 15) begin
        lit("t3_full", 32'(bus.full_o), 32'd1);
        lit("t3_no_ovf_yet", 32'(bus.ovf_o), 32'd0);
      end
    end
    lit("t3_ovf", 32'(bus.ovf_o), 32'd1);

    // 4: push into a full FIFO on the same edge as a pop
    flush();
    for (int i = 0; i < 16; i++) push_word(32'h400 + 32'(i));
    lit("t4_full", 32'(bus.full_o), 32'd1);
    bus.en_i = 1'b1;
    step();
    push_word(32'h4FF);
    lit("t4_tick", 32'(bus.tick_o), 32'd1);
    lit("t4_data", bus.data_o, 32'h400);
    lit("t4_ovf", 32'(bus.ovf_o), 32'd0);
    lit("t4_still_full", 32'(bus.full_o), 32'd1);
    bus.en_i = 1'b0;
    step();

    // 5: divider change mid-period, pause and resume
    flush();
    set_div(9);
    for (int i = 0; i < 6; i++) push_word(32'h500 + 32'(i));
    bus.en_i = 1'b1;
    step();
    wait_tick(15, n);
    lit("t5_latency", 32'(n), 32'd10);
    lit("t5_word0", bus.data_o, 32'h500);
    repeat (3) step();
    set_div(1);
    wait_tick(5, n);
    lit("t5_after_setdiv", 32'(n), 32'd2);
    lit("t5_word1", bus.data_o, 32'h501);
    wait_tick(5, n);
    lit("t5_period2", 32'(n), 32'd2);
    lit("t5_word2", bus.data_o, 32'h502);
    bus.en_i = 1'b0;
    repeat (5) step();
    lit("t5_paused_hold", bus.data_o, 32'h502);
    bus.en_i = 1'b1;
    step();
    wait_tick(5, n);
    lit("t5_resume", 32'(n), 32'd2);
    lit("t5_word3", bus.data_o, 32'h503);

    // 6: asynchronous reset mid-run, then flush behaviour
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    lit("t6_rst_data",  bus.data_o, 32'h0);
    lit("t6_rst_tick",  32'(bus.tick_o), 32'd0);
    lit("t6_rst_empty", 32'(bus.empty_o), 32'd1);
    lit("t6_rst_ovf",   32'(bus.ovf_o), 32'd0);
    lit("t6_rst_udf",   32'(bus.udf_o), 32'd0);
    bus.en_i = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    set_div(0);
    push_word(32'h600);
    push_word(32'h601);
    bus.en_i = 1'b1;
    repeat (5) step();
    bus.en_i = 1'b0;
    step();
    for (int i = 0; i < 17; i++) push_word(32'h700 + 32'(i));
    lit("t6_pre_ovf", 32'(bus.ovf_o), 32'd1);
    lit("t6_pre_udf", 32'(bus.udf_o), 32'd1);
    flush();
    lit("t6_clr_data",  bus.data_o, 32'h601);
    lit("t6_clr_ovf",   32'(bus.ovf_o), 32'd0);
    lit("t6_clr_udf",   32'(bus.udf_o), 32'd0);
    lit("t6_clr_empty", 32'(bus.empty_o), 32'd1);

    // Randomized traffic checked every cycle against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) bus.en_i = ~bus.en_i;
      if ($urandom_range(0, 49) == 0) begin
        bus.set_div_i = 1'b1;
        bus.fdiv_i    = 24'($urandom_range(0, 4));
      end
      if ((i % 600) < 300) bus.stb_i = ($urandom_range(0, 2) != 0);
      else                 bus.stb_i = ($urandom_range(0, 3) == 0);
      bus.smpls_i = $urandom;
      if ($urandom_range(0, 199) == 0) bus.clr_i = 1'b1;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
